// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational RV32I ALU between two requesters,
// issuing one operation at a time and returning registered results round-robin.
module alu_arbiter #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_op_a,
    input  logic [31:0] req0_op_b,
    input  logic [2:0]  req0_funct3,
    input  logic        req0_op_sign,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_op_a,
    input  logic [31:0] req1_op_b,
    input  logic [2:0]  req1_funct3,
    input  logic        req1_op_sign,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_negative,
    output logic        rsp_overflow,
    output logic        busy,
    output logic        alu_execute,
    output logic [31:0] alu_op_a,
    output logic [31:0] alu_op_b,
    output logic [2:0]  alu_funct3,
    output logic        alu_op_sign,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_overflow
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_next;
    logic owner, ptr, grant, accept, rsp_done;
    // with a single valid requester it wins; the pointer only breaks ties
    assign grant    = (req0_valid & req1_valid) ? ptr : req1_valid;
    assign accept   = (state == IDLE) & (req0_valid | req1_valid);
    assign rsp_done = (state == RESP) & (owner ? rsp1_ready : rsp0_ready);
    always_comb begin
        state_next  = state;
        req0_ready  = accept & ~grant;
        req1_ready  = accept & grant;
        busy        = state != IDLE;
        alu_execute = state == ISSUE;
        rsp0_valid  = (state == RESP) & ~owner;
        rsp1_valid  = (state == RESP) & owner;
        case (state)
            IDLE:    state_next = accept ? ISSUE : IDLE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = rsp_done ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= 1'b0;
            ptr          <= PRIO_INIT;
            alu_op_a     <= '0;
            alu_op_b     <= '0;
            alu_funct3   <= '0;
            alu_op_sign  <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_negative <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner       <= grant;
                alu_op_a    <= grant ? req1_op_a : req0_op_a;
                alu_op_b    <= grant ? req1_op_b : req0_op_b;
                alu_funct3  <= grant ? req1_funct3 : req0_funct3;
                alu_op_sign <= grant ? req1_op_sign : req0_op_sign;
            end
            if (state == ISSUE) begin
                rsp_result   <= alu_result;
                rsp_zero     <= alu_zero;
                rsp_negative <= alu_negative;
                rsp_overflow <= alu_overflow;
            end
            if (rsp_done)
                ptr <= ~owner;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table, hand sequences and a randomized run against
// a cycle-level reference model of the arbitration and response rules.
module tb_alu_arbiter;
    logic clk = 1'b0, reset;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_op_a, req0_op_b, req1_op_a, req1_op_b;
    logic [2:0] req0_funct3, req1_funct3;
    logic req0_op_sign, req1_op_sign;
    logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic rsp_zero, rsp_negative, rsp_overflow, busy, alu_execute;
    logic [31:0] alu_op_a, alu_op_b, alu_result;
    logic [2:0] alu_funct3;
    logic alu_op_sign, alu_zero, alu_negative, alu_overflow;
    logic [31:0] junk = 32'h0;
    int checks = 0, errors = 0;

    typedef struct {
        logic p; logic [31:0] a, b; logic [2:0] f; logic s;
        logic [31:0] r; logic z, n, o;
    } vec_t;
    vec_t vt[10];

    alu_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op_a(req0_op_a),
        .req0_op_b(req0_op_b), .req0_funct3(req0_funct3), .req0_op_sign(req0_op_sign),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op_a(req1_op_a),
        .req1_op_b(req1_op_b), .req1_funct3(req1_funct3), .req1_op_sign(req1_op_sign),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_negative(rsp_negative),
        .rsp_overflow(rsp_overflow), .busy(busy), .alu_execute(alu_execute),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_funct3(alu_funct3),
        .alu_op_sign(alu_op_sign), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_negative(alu_negative), .alu_overflow(alu_overflow)
    );

    always #5 clk = ~clk;

    // returns {overflow, negative, zero, result}
    function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f, input logic s);
        longint sa, sb, r64;
        logic [31:0] r;
        logic o;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        o = 1'b0;
        r = '0;
        case (f)
            3'd0: begin
                r64 = s ? sa - sb : sa + sb;
                r = r64[31:0];
                o = r64 != longint'($signed(r));
            end
            3'd1: r = a << b[4:0];
            3'd2: r = {31'b0, sa < sb};
            3'd3: r = {31'b0, a < b};
            3'd4: r = a ^ b;
            3'd5: if (s) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return {o, r[31], r == 32'd0, r};
    endfunction

    // outside the execute cycle the ALU presents garbage so a mistimed capture shows up
    always_comb {alu_overflow, alu_negative, alu_zero, alu_result} =
        alu_execute ? alu_f(alu_op_a, alu_op_b, alu_funct3, alu_op_sign) : {3'b111, junk};
    always @(negedge clk) junk <= $urandom;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic p, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] f, input logic s);
        if (p) begin
            req1_valid = v; req1_op_a = a; req1_op_b = b; req1_funct3 = f; req1_op_sign = s;
        end else begin
            req0_valid = v; req0_op_a = a; req0_op_b = b; req0_funct3 = f; req0_op_sign = s;
        end
    endtask

    task automatic new_payload(input logic p);
        set_req(p, 1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        set_req(v.p, 1'b1, v.a, v.b, v.f, v.s);
        @(negedge clk);
        chk("req_ready", v.p ? req1_ready : req0_ready, 1);
        chk("other_ready", v.p ? req0_ready : req1_ready, 0);
        chk("exec_idle", alu_execute, 0);
        @(posedge clk); #1;
        if (v.p) req1_valid = 1'b0; else req0_valid = 1'b0;
        @(negedge clk);
        chk("exec_issue", {busy, alu_execute}, 3);
        chk("ready_issue", {req1_ready, req0_ready}, 0);
        chk("alu_op_a", alu_op_a, v.a);
        chk("alu_op_b", alu_op_b, v.b);
        chk("alu_ctl", {alu_funct3, alu_op_sign}, {v.f, v.s});
        @(posedge clk); #1;
        @(negedge clk);
        chk("exec_resp", alu_execute, 0);
        chk("rsp_valid", {rsp1_valid, rsp0_valid}, v.p ? 2 : 1);
        chk("rsp_result", rsp_result, v.r);
        chk("rsp_flags", {rsp_zero, rsp_negative, rsp_overflow}, {v.z, v.n, v.o});
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_after", {busy, rsp1_valid, rsp0_valid}, 0);
    endtask

    logic [34:0] exp_q[$], got, me;
    logic gp_q[$];
    logic mb, mo, mp, any, w, acc0, acc1;
    int ngr, nrsp, last_g, age;

    initial begin
        vt[0] = '{1'b0, 32'd5, 32'd7, 3'd0, 1'b0, 32'd12, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 32'h80000000, 32'd1, 3'd0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
        vt[2] = '{1'b0, 32'd3, 32'd5, 3'd0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
        vt[3] = '{1'b1, 32'd5, 32'd5, 3'd0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0};
        vt[4] = '{1'b0, 32'h7FFFFFFF, 32'd1, 3'd0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1};
        vt[5] = '{1'b1, 32'd1, 32'd4, 3'd1, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b0, 32'h80000000, 32'd4, 3'd5, 1'b1, 32'hF8000000, 1'b0, 1'b1, 1'b0};
        vt[7] = '{1'b1, 32'hFFFFFFFF, 32'd1, 3'd2, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0};
        vt[8] = '{1'b0, 32'hFFFFFFFF, 32'd1, 3'd3, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0};
        vt[9] = '{1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd7, 1'b0, 32'h00F000F0, 1'b0, 1'b0, 1'b0};
        reset = 1'b1;
        set_req(1'b0, 1'b0, '0, '0, '0, 1'b0);
        set_req(1'b1, 1'b0, '0, '0, '0, 1'b0);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #7;
        chk("reset_ctl", {busy, alu_execute, rsp1_valid, rsp0_valid, req1_ready, req0_ready}, 0);
        chk("reset_rsp", {rsp_zero, rsp_negative, rsp_overflow, rsp_result}, 0);
        chk("reset_alu", {alu_op_a, alu_op_b, alu_funct3, alu_op_sign}, 0);
        #1 reset = 1'b0;

        // round robin: both ports held valid for four operations
        ngr = 0; nrsp = 0; last_g = 0;
        @(posedge clk); #1;
        new_payload(1'b0); new_payload(1'b1);
        for (int c = 0; c < 40 && nrsp < 4; c++) begin
            @(negedge clk);
            chk("rr_not_both", {31'b0, req0_ready & req1_ready}, 0);
            acc0 = req0_ready & req0_valid;
            acc1 = req1_ready & req1_valid;
            if (acc0 | acc1) begin
                chk("rr_order", req1_ready, ngr % 2);
                if (ngr > 0) chk("rr_interval", c - last_g, 3);
                exp_q.push_back(acc1 ? alu_f(req1_op_a, req1_op_b, req1_funct3, req1_op_sign)
                                     : alu_f(req0_op_a, req0_op_b, req0_funct3, req0_op_sign));
                gp_q.push_back(acc1);
                last_g = c;
                ngr++;
            end
            if ((rsp0_valid | rsp1_valid) && exp_q.size() > 0) begin
                chk("rr_rsp_port", {rsp1_valid, rsp0_valid}, gp_q.pop_front() ? 2 : 1);
                chk("rr_result", {rsp_overflow, rsp_negative, rsp_zero, rsp_result}, exp_q.pop_front());
                nrsp++;
            end
            @(posedge clk); #1;
            if (acc0) new_payload(1'b0);
            if (acc1) new_payload(1'b1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_count", nrsp, 4);

        foreach (vt[i]) run_vec(vt[i]);

        // response backpressure with port 1 waiting
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        set_req(1'b0, 1'b1, 32'h10, 32'h20, 3'd0, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        set_req(1'b1, 1'b1, 32'h3, 32'h4, 3'd4, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {rsp1_valid, rsp0_valid, req1_ready}, 3'b010);
            chk("bp_result", {rsp_zero, rsp_negative, rsp_overflow, rsp_result}, 32'h30);
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", rsp0_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_grant1", {busy, req1_ready, req0_ready}, 3'b010);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_rsp1", {rsp1_valid, rsp0_valid}, 2);
        chk("bp_result1", rsp_result, 32'h7);

        // withdrawn request from port 1 while port 0 is served
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        set_req(1'b0, 1'b1, 32'h100, 32'h1, 3'd0, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        set_req(1'b1, 1'b1, 32'h55, 32'h66, 3'd0, 1'b0);
        @(negedge clk);
        chk("wd_ready_issue", req1_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wd_ready_resp", req1_ready, 0);
        @(posedge clk); #1;
        req1_valid = 1'b0; rsp0_ready = 1'b1;
        @(negedge clk);
        chk("wd_rsp0", {rsp0_valid, rsp_result}, {1'b1, 32'hFF});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("wd_quiet", {rsp1_valid, req1_ready, busy}, 0);
        end
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 32'h1, 32'h1, 3'd0, 1'b0);
        set_req(1'b1, 1'b1, 32'h9, 32'h1, 3'd0, 1'b0);
        @(negedge clk);
        chk("wd_ptr", {req1_ready, req0_ready}, 2);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wd_rsp1", {rsp1_valid, rsp_result}, {1'b1, 32'hA});

        // asynchronous reset during ISSUE
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 32'h1234, 32'h1, 3'd0, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_ctl", {alu_execute, busy, rsp1_valid, rsp0_valid}, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_alu_a", alu_op_a, 0);
        @(posedge clk); #3 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_no_stale", {busy, rsp1_valid, rsp0_valid}, 0);
        end
        run_vec(vt[0]);

        // randomized traffic against the reference model
        @(posedge clk); #1 reset = 1'b1;
        #3 reset = 1'b0;
        mb = 1'b0; mo = 1'b0; mp = 1'b0; age = 0; acc0 = 1'b0; acc1 = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            if (!req0_valid || acc0) begin
                if ($urandom_range(0, 1) == 1) new_payload(1'b0); else req0_valid = 1'b0;
            end else if ($urandom_range(0, 7) == 0) req0_valid = 1'b0;
            if (!req1_valid || acc1) begin
                if ($urandom_range(0, 1) == 1) new_payload(1'b1); else req1_valid = 1'b0;
            end else if ($urandom_range(0, 7) == 0) req1_valid = 1'b0;
            rsp0_ready = $urandom_range(0, 2) != 0;
            rsp1_ready = $urandom_range(0, 2) != 0;
            @(negedge clk);
            acc0 = req0_valid & req0_ready;
            acc1 = req1_valid & req1_ready;
            if (!mb) begin
                any = req0_valid | req1_valid;
                w = (req0_valid & req1_valid) ? mp : req1_valid;
                chk("m_idle", {busy, alu_execute, rsp1_valid, rsp0_valid}, 0);
                chk("m_grant", {req1_ready, req0_ready}, any ? (w ? 2 : 1) : 0);
                if (any) begin
                    mb = 1'b1; mo = w; age = 1;
                    me = w ? alu_f(req1_op_a, req1_op_b, req1_funct3, req1_op_sign)
                           : alu_f(req0_op_a, req0_op_b, req0_funct3, req0_op_sign);
                end
            end else begin
                chk("m_busy", {busy, req1_ready, req0_ready}, 3'b100);
                chk("m_exec", alu_execute, age == 1);
                if (age == 1) begin
                    chk("m_no_rsp", {rsp1_valid, rsp0_valid}, 0);
                    age = 2;
                end else begin
                    chk("m_rsp_port", {rsp1_valid, rsp0_valid}, mo ? 2 : 1);
                    got = {rsp_overflow, rsp_negative, rsp_zero, rsp_result};
                    chk("m_rsp_result", got[31:0], me[31:0]);
                    chk("m_rsp_flags", got[34:32], me[34:32]);
                    if (mo ? rsp1_ready : rsp0_ready) begin
                        mb = 1'b0; mp = ~mo;
                    end
                end
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
